// File: rtl/rand_word_arbiter.sv
// -----------------------------------------------------------------------------
// rand_word_arbiter
//
// Shares one serial random-bit generator (an LFSR producing one bit per clock)
// between two requesters. A granted requester receives WIDTH consecutive
// generator bits packed into a word, together with a one-cycle acknowledge.
// The block also sequences generator reseeding. It pulses the generator's
// active-low reset for one clock and then discards WARMUP bits before it
// serves requests again.
//
// Parameters
//   WIDTH   bits per delivered word (2..16)
//   WARMUP  generator bits discarded after a reseed (0..255, 0 = none)
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-low reset
//   rand_i       serial bit from the generator, one new bit per clock
//   reseed_i     single-cycle reseed request
//   req_i[1:0]   per-requester level request, held until the matching ack
//   lfsr_rst_no  active-low reset to the generator (registered)
//   ack_o[1:0]   one-hot, single-cycle "word_o valid for this requester"
//   word_o       last delivered word, held until the next delivery
//   busy_o       high in every state except IDLE
// -----------------------------------------------------------------------------
module rand_word_arbiter #(
  parameter int WIDTH  = 4,
  parameter int WARMUP = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rand_i,
  input  logic             reseed_i,
  input  logic [1:0]       req_i,
  output logic             lfsr_rst_no,
  output logic [1:0]       ack_o,
  output logic [WIDTH-1:0] word_o,
  output logic             busy_o
);

  // The counter must reach the larger of the two limits. It restarts from
  // zero on every state entry, so it never has to wrap.
  localparam int CNT_MAX = (WIDTH > WARMUP) ? WIDTH : WARMUP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_DONE,
    S_RESEED,
    S_WARMUP
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] word_q;
  logic [1:0]       ack_q;
  logic             grant_q;
  logic             rr_q;
  logic             reseed_pend_q;
  logic             lfsr_rst_n_q;
  logic             busy_q;

  // The first sampled bit shifts up to become the MSB of the finished word.
  assign shift_d = {shift_q[WIDTH-2:0], rand_i};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      word_q        <= '0;
      ack_q         <= '0;
      grant_q       <= 1'b0;
      rr_q          <= 1'b0;
      reseed_pend_q <= 1'b0;
      lfsr_rst_n_q  <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      // These defaults make ack and the generator reset single-cycle pulses.
      ack_q        <= '0;
      lfsr_rst_n_q <= 1'b1;

      // A reseed that arrives while busy is remembered. It is serviced at the
      // next IDLE, so a word already in flight is never cut short.
      if (reseed_i && (state_q != S_IDLE)) begin
        reseed_pend_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (reseed_i || reseed_pend_q) begin
            reseed_pend_q <= 1'b0;
            lfsr_rst_n_q  <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= S_RESEED;
          end else if (req_i != 2'b00) begin
            // A single request wins outright. A tie goes to the rr pointer.
            grant_q <= (req_i == 2'b11) ? rr_q : req_i[1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_GATHER;
          end
        end

        S_GATHER: begin
          shift_q <= shift_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            word_q         <= shift_d;
            ack_q[grant_q] <= 1'b1;
            rr_q           <= ~grant_q;
            state_q        <= S_DONE;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        S_RESEED: begin
          cnt_q <= '0;
          if (WARMUP == 0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_WARMUP;
          end
        end

        S_WARMUP: begin
          // rand_i is ignored here. The generator output is still settling.
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WARMUP - 1)) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign lfsr_rst_no = lfsr_rst_n_q;
  assign ack_o       = ack_q;
  assign word_o      = word_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_rand_word_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rand_word_arbiter
//
// The bench applies a table of directed vectors, one clock per record. Each
// record holds the inputs to apply and the outputs expected just after the
// following rising edge. A hand-written sequence covers asynchronous reset
// in the middle of a word.
// -----------------------------------------------------------------------------
module tb_rand_word_arbiter;

  localparam int WIDTH  = 4;
  localparam int WARMUP = 8;

  logic             clk_i;
  logic             rst_i;
  logic             rand_i;
  logic             reseed_i;
  logic [1:0]       req_i;
  logic             lfsr_rst_no;
  logic [1:0]       ack_o;
  logic [WIDTH-1:0] word_o;
  logic             busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  rand_word_arbiter #(.WIDTH(WIDTH), .WARMUP(WARMUP)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rand_i     (rand_i),
    .reseed_i   (reseed_i),
    .req_i      (req_i),
    .lfsr_rst_no(lfsr_rst_no),
    .ack_o      (ack_o),
    .word_o     (word_o),
    .busy_o     (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst_n;
    logic       reseed;
    logic [1:0] req;
    logic       rnd;
    logic       e_lfsr;
    logic [1:0] e_ack;
    logic [3:0] e_word;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic rst_n, input logic reseed, input logic [1:0] req,
                            input logic rnd, input logic e_lfsr, input logic [1:0] e_ack,
                            input logic [3:0] e_word, input logic e_busy);
    vec_t r;
    r.rst_n = rst_n; r.reseed = reseed; r.req = req; r.rnd = rnd;
    r.e_lfsr = e_lfsr; r.e_ack = e_ack; r.e_word = e_word; r.e_busy = e_busy;
    vecs.push_back(r);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic chk_outs(input string name, input logic e_lfsr, input logic [1:0] e_ack,
                          input logic [3:0] e_word, input logic e_busy);
    n_cmp++;
    if ({lfsr_rst_no, ack_o, word_o, busy_o} !== {e_lfsr, e_ack, e_word, e_busy}) begin
      n_bad++;
      $display("FAIL %s: lfsr_rst_no=%b ack=%b word=%h busy=%b expected lfsr_rst_no=%b ack=%b word=%h busy=%b",
               name, lfsr_rst_no, ack_o, word_o, busy_o, e_lfsr, e_ack, e_word, e_busy);
    end else begin
      $display("ok   %s: lfsr_rst_no=%b ack=%b word=%h busy=%b",
               name, lfsr_rst_no, ack_o, word_o, busy_o);
    end
  endtask

  initial begin
    // ---------------- vector table ----------------
    // Test 1: a single held request. Bits 1,0,1,1 give 1011. The request is
    // re-acked six cycles later with bits 0,1,0,0.
    v(1,0,2'b01,0, 1,2'b00,4'h0,1);   // e0 grant
    v(1,0,2'b01,1, 1,2'b00,4'h0,1);   // e1
    v(1,0,2'b01,0, 1,2'b00,4'h0,1);   // e2
    v(1,0,2'b01,1, 1,2'b00,4'h0,1);   // e3
    v(1,0,2'b01,1, 1,2'b01,4'hB,1);   // e4 ack
    v(1,0,2'b01,0, 1,2'b00,4'hB,0);   // e5 idle
    v(1,0,2'b01,0, 1,2'b00,4'hB,1);   // e6 regrant
    v(1,0,2'b01,0, 1,2'b00,4'hB,1);
    v(1,0,2'b01,1, 1,2'b00,4'hB,1);
    v(1,0,2'b01,0, 1,2'b00,4'hB,1);
    v(1,0,2'b01,0, 1,2'b01,4'h4,1);   // e10 ack
    v(1,0,2'b00,0, 1,2'b00,4'h4,0);
    v(1,0,2'b00,0, 1,2'b00,4'h4,0);
    // Test 2: a tie held from reset. Acks go 01,10,01,10.
    v(0,0,2'b00,0, 1,2'b00,4'h0,0);   // reset
    v(1,0,2'b11,0, 1,2'b00,4'h0,1);   // grant 0
    v(1,0,2'b11,0, 1,2'b00,4'h0,1);
    v(1,0,2'b11,1, 1,2'b00,4'h0,1);
    v(1,0,2'b11,1, 1,2'b00,4'h0,1);
    v(1,0,2'b11,0, 1,2'b01,4'h6,1);
    v(1,0,2'b11,0, 1,2'b00,4'h6,0);
    v(1,0,2'b11,0, 1,2'b00,4'h6,1);   // grant 1
    v(1,0,2'b11,1, 1,2'b00,4'h6,1);
    v(1,0,2'b11,1, 1,2'b00,4'h6,1);
    v(1,0,2'b11,0, 1,2'b00,4'h6,1);
    v(1,0,2'b11,1, 1,2'b10,4'hD,1);
    v(1,0,2'b11,0, 1,2'b00,4'hD,0);
    v(1,0,2'b11,0, 1,2'b00,4'hD,1);   // grant 0
    v(1,0,2'b11,1, 1,2'b00,4'hD,1);
    v(1,0,2'b11,0, 1,2'b00,4'hD,1);
    v(1,0,2'b11,0, 1,2'b00,4'hD,1);
    v(1,0,2'b11,0, 1,2'b01,4'h8,1);
    v(1,0,2'b11,0, 1,2'b00,4'h8,0);
    v(1,0,2'b11,0, 1,2'b00,4'h8,1);   // grant 1
    v(1,0,2'b11,0, 1,2'b00,4'h8,1);
    v(1,0,2'b11,0, 1,2'b00,4'h8,1);
    v(1,0,2'b11,1, 1,2'b00,4'h8,1);
    v(1,0,2'b11,1, 1,2'b10,4'h3,1);
    v(1,0,2'b00,0, 1,2'b00,4'h3,0);
    v(1,0,2'b00,0, 1,2'b00,4'h3,0);
    // Test 3: a reseed from idle. The generator reset is low for one cycle
    // and busy is high for nine. A request made during warmup waits.
    v(1,1,2'b00,0, 0,2'b00,4'h3,1);   // e0 RESEED
    v(1,0,2'b00,1, 1,2'b00,4'h3,1);   // e1 WARMUP
    v(1,0,2'b00,1, 1,2'b00,4'h3,1);   // e2
    v(1,0,2'b10,0, 1,2'b00,4'h3,1);   // e3
    v(1,0,2'b10,1, 1,2'b00,4'h3,1);
    v(1,0,2'b10,0, 1,2'b00,4'h3,1);
    v(1,0,2'b10,1, 1,2'b00,4'h3,1);
    v(1,0,2'b10,0, 1,2'b00,4'h3,1);
    v(1,0,2'b10,1, 1,2'b00,4'h3,1);   // e8
    v(1,0,2'b10,1, 1,2'b00,4'h3,0);   // e9 back to idle
    v(1,0,2'b10,0, 1,2'b00,4'h3,1);   // e10 grant 1
    v(1,0,2'b10,1, 1,2'b00,4'h3,1);
    v(1,0,2'b10,0, 1,2'b00,4'h3,1);
    v(1,0,2'b10,0, 1,2'b00,4'h3,1);
    v(1,0,2'b10,1, 1,2'b10,4'h9,1);   // e14 ack
    v(1,0,2'b00,0, 1,2'b00,4'h9,0);
    // Test 4: a reseed at e2 of a requester-0 word. The word completes, then
    // the reseed runs ahead of the pending req=10.
    v(1,0,2'b01,0, 1,2'b00,4'h9,1);   // e0 grant 0
    v(1,0,2'b10,1, 1,2'b00,4'h9,1);
    v(1,1,2'b10,1, 1,2'b00,4'h9,1);   // e2 reseed
    v(1,0,2'b10,1, 1,2'b00,4'h9,1);
    v(1,0,2'b10,0, 1,2'b01,4'hE,1);   // e4 ack
    v(1,0,2'b10,0, 1,2'b00,4'hE,0);   // e5 idle
    v(1,0,2'b10,0, 0,2'b00,4'hE,1);   // e6 RESEED
    v(1,0,2'b10,0, 1,2'b00,4'hE,1);   // e7 WARMUP
    for (int k = 0; k < 7; k++) v(1,0,2'b10,k[0], 1,2'b00,4'hE,1);
    v(1,0,2'b10,0, 1,2'b00,4'hE,0);   // e15 idle
    v(1,0,2'b10,0, 1,2'b00,4'hE,1);   // e16 grant 1
    v(1,0,2'b10,0, 1,2'b00,4'hE,1);
    v(1,0,2'b10,1, 1,2'b00,4'hE,1);
    v(1,0,2'b10,0, 1,2'b00,4'hE,1);
    v(1,0,2'b10,1, 1,2'b10,4'h5,1);
    v(1,0,2'b00,0, 1,2'b00,4'h5,0);
    // Test 5: the request is dropped at e2. The ack still pulses and no
    // further grant follows.
    v(1,0,2'b01,0, 1,2'b00,4'h5,1);
    v(1,0,2'b01,0, 1,2'b00,4'h5,1);
    v(1,0,2'b00,0, 1,2'b00,4'h5,1);
    v(1,0,2'b00,1, 1,2'b00,4'h5,1);
    v(1,0,2'b00,0, 1,2'b01,4'h2,1);
    v(1,0,2'b00,0, 1,2'b00,4'h2,0);
    v(1,0,2'b00,0, 1,2'b00,4'h2,0);
    v(1,0,2'b00,0, 1,2'b00,4'h2,0);

    // ---------------- reset state ----------------
    rst_i = 1'b0; rand_i = 1'b0; reseed_i = 1'b0; req_i = 2'b00;
    tick();
    tick();
    chk_outs("reset_state", 1'b1, 2'b00, 4'h0, 1'b0);

    // ---------------- table application ----------------
    foreach (vecs[i]) begin
      rst_i    = vecs[i].rst_n;
      reseed_i = vecs[i].reseed;
      req_i    = vecs[i].req;
      rand_i   = vecs[i].rnd;
      tick();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_lfsr, vecs[i].e_ack,
               vecs[i].e_word, vecs[i].e_busy);
    end

    // ---------------- async reset mid-GATHER ----------------
    // Test 5 left the rr pointer at 1, so this tie grants requester 1.
    req_i = 2'b11; rand_i = 1'b0;
    tick();                                   // e0 grant
    rand_i = 1'b1; tick();                    // e1
    rand_i = 1'b0; tick();                    // e2
    rand_i = 1'b1; tick();                    // e3
    chk("arst_busy_before", {31'd0, busy_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk_outs("arst_immediate", 1'b1, 2'b00, 4'h0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    // After release the rr pointer is back at 0, so the tie grants 0.
    rand_i = 1'b0; tick();                    // e0' grant
    rand_i = 1'b1; tick();                    // e1'
    rand_i = 1'b1; tick();                    // e2'
    rand_i = 1'b0; tick();                    // e3'
    chk("arst_no_early_ack", {30'd0, ack_o}, 32'd0);
    rand_i = 1'b0; tick();                    // e4'
    chk_outs("arst_first_tie", 1'b1, 2'b01, 4'hC, 1'b1);
    req_i = 2'b00;
    tick();
    chk_outs("arst_done", 1'b1, 2'b00, 4'hC, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
